// File: rtl/lsu_pkg_rv32i.sv
// Shared encodings for the RV32I load/store sequencer: access types, sizes and FSM states.
package lsu_pkg_rv32i;

  typedef enum logic [2:0] {
    LT_LB  = 3'b000,
    LT_LH  = 3'b001,
    LT_LW  = 3'b010,
    LT_LBU = 3'b011,
    LT_LHU = 3'b100
  } loadtype_e;

  typedef enum logic [1:0] {
    ST_SB = 2'b00,
    ST_SH = 2'b01,
    ST_SW = 2'b10
  } storetype_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  // Reserved encodings fall through to word.
  function automatic lsu_size_e load_size(logic [2:0] lt);
    case (lt)
      LT_LB, LT_LBU: return SZ_B;
      LT_LH, LT_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

  function automatic lsu_size_e store_size(logic [1:0] st);
    case (st)
      ST_SB:   return SZ_B;
      ST_SH:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_rv32i_if.sv
// Word-wide data memory bus with req/ack handshake; master is the LSU, slave is the memory.
interface lsu_ctrl_rv32i_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/lsu_lane_rv32i.sv
// Combinational byte-lane steering: store enables/replicated data, and load data extension.
module lsu_lane_rv32i
  import lsu_pkg_rv32i::*;
(
  input  logic        store_i,
  input  logic [2:0]  loadtype_i,
  input  logic [1:0]  storetype_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ext_loadtype_i,
  input  logic [1:0]  ext_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);
  lsu_size_e   size;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign size = store_i ? store_size(storetype_i) : load_size(loadtype_i);

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size)
      SZ_B: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o    = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  assign byte_sel = rdata_i[{ext_off_i, 3'b000} +: 8];
  assign half_sel = ext_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    rdata_o = rdata_i;
    case (ext_loadtype_i)
      LT_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  rdata_o = {24'h0, byte_sel};
      LT_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  rdata_o = {16'h0, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end
endmodule

// File: rtl/lsu_ctrl_rv32i.sv
// RV32I load/store sequencer: IDLE->REQ->DONE/ERR, min 3 cycles; stalls the core until done/err.
// MISALIGN_TRAP_EN: misaligned half/word accesses error out in IDLE instead of aligning down.
module lsu_ctrl_rv32i
  import lsu_pkg_rv32i::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_load_i,
  input  logic              lsu_store_i,
  input  logic [2:0]        lsu_loadtype_i,
  input  logic [1:0]        lsu_storetype_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [31:0]       lsu_rdata_o,
  lsu_ctrl_rv32i_if.master  mem
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        ldtype_q, ldtype_d;
  logic [1:0]        off_q, off_d;

  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              trap;

  lsu_lane_rv32i u_lane (
    .store_i        (lsu_store_i),
    .loadtype_i     (lsu_loadtype_i),
    .storetype_i    (lsu_storetype_i),
    .off_i          (lsu_addr_i[1:0]),
    .wdata_i        (lsu_wdata_i),
    .be_o           (lane_be),
    .wdata_o        (lane_wdata),
    .ext_loadtype_i (ldtype_q),
    .ext_off_i      (off_q),
    .rdata_i        (mem.mem_rdata),
    .rdata_o        (lane_rdata)
  );

`ifdef MISALIGN_TRAP_EN
  lsu_size_e acc_size;
  assign acc_size = lsu_store_i ? store_size(lsu_storetype_i) : load_size(lsu_loadtype_i);
  assign trap = ((acc_size == SZ_H) && lsu_addr_i[0]) ||
                ((acc_size == SZ_W) && (lsu_addr_i[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ldtype_q <= '0;
      off_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ldtype_q <= ldtype_d;
      off_q    <= off_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ldtype_d    = ldtype_q;
    off_d       = off_q;
    lsu_stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_stall_o = lsu_load_i | lsu_store_i;
        if ((lsu_load_i && lsu_store_i) || ((lsu_load_i || lsu_store_i) && trap)) begin
          state_d = S_ERR;
          rdata_d = '0;
        end else if (lsu_load_i || lsu_store_i) begin
          state_d  = S_REQ;
          req_d    = 1'b1;
          we_d     = lsu_store_i;
          addr_d   = {lsu_addr_i[ADDR_W-1:2], 2'b00};
          be_d     = lane_be;
          wdata_d  = lane_wdata;
          ldtype_d = lsu_loadtype_i;
          off_d    = lsu_addr_i[1:0];
          cnt_d    = '0;
          rdata_d  = '0;
        end
      end
      S_REQ: begin
        lsu_stall_o = 1'b1;
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem.mem_ack) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : lane_rdata;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_ERR;
          req_d   = 1'b0;
          rdata_d = '0;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign lsu_done_o    = (state_q == S_DONE);
  assign lsu_err_o     = (state_q == S_ERR);
  assign lsu_rdata_o   = rdata_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_lsu_ctrl_rv32i.sv
// Scoreboard bench for lsu_ctrl_rv32i: driver pushes reference-model expectations, monitor checks responses.
module tb_lsu_ctrl_rv32i;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_load, lsu_store;
  logic [2:0]  lsu_loadtype;
  logic [1:0]  lsu_storetype;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_stall, lsu_done, lsu_err;
  logic [31:0] lsu_rdata;

  always #5 clk = ~clk;

  lsu_ctrl_rv32i_if #(.ADDR_W(ADDR_W)) mif ();

  lsu_ctrl_rv32i #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .lsu_load_i      (lsu_load),
    .lsu_store_i     (lsu_store),
    .lsu_loadtype_i  (lsu_loadtype),
    .lsu_storetype_i (lsu_storetype),
    .lsu_addr_i      (lsu_addr),
    .lsu_wdata_i     (lsu_wdata),
    .lsu_stall_o     (lsu_stall),
    .lsu_done_o      (lsu_done),
    .lsu_err_o       (lsu_err),
    .lsu_rdata_o     (lsu_rdata),
    .mem             (mif.master)
  );

  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          req_cyc;
    int          stall_cyc;
    logic [31:0] addr;
    logic [3:0]  be;
    bit          we;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cur_delay = 0;
  logic [31:0] cur_rdata = 32'h0;
  int          ev_cnt = 0;
  int          req_cnt = 0;
  int          stall_cnt = 0;
  bit          req_prev = 1'b0;
  int          ridx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  // Reference model: derived from access size in bytes and the aligned-down lane offset.
  function automatic exp_t model(input bit ld, input bit sto, input logic [2:0] ltv,
                                 input logic [1:0] stv, input logic [31:0] a,
                                 input logic [31:0] wd, input int delay, input logic [31:0] rd);
    exp_t e;
    int nb, off, al;
    logic [31:0] v;
    off = int'(a[1:0]);
    if (sto) nb = (stv == 2'd0) ? 1 : (stv == 2'd1) ? 2 : 4;
    else     nb = (ltv == 3'd0 || ltv == 3'd3) ? 1 : (ltv == 3'd1 || ltv == 3'd4) ? 2 : 4;
    al = (off / nb) * nb;
    e.err       = 1'b0;
    e.rdata     = 32'h0;
    e.req_cyc   = 0;
    e.stall_cyc = 1;
    e.addr      = {a[31:2], 2'b00};
    e.we        = sto;
    e.be        = 4'(((1 << nb) - 1) << al);
    e.wdata     = (nb == 1) ? {4{wd[7:0]}} : (nb == 2) ? {2{wd[15:0]}} : wd;
    if (ld && sto) begin
      e.err = 1'b1;
      return e;
    end
`ifdef MISALIGN_TRAP_EN
    if (al != off) begin
      e.err = 1'b1;
      return e;
    end
`endif
    if (delay >= TIMEOUT) begin
      e.err       = 1'b1;
      e.req_cyc   = TIMEOUT;
      e.stall_cyc = TIMEOUT + 1;
      return e;
    end
    e.req_cyc   = delay + 1;
    e.stall_cyc = delay + 2;
    if (ld) begin
      v = rd >> (8 * al);
      if (nb == 1) begin
        v = v & 32'hFF;
        if (ltv == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end else if (nb == 2) begin
        v = v & 32'hFFFF;
        if (ltv == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  // Memory responder: acks after cur_delay wait cycles, random ack/rdata noise outside REQ.
  initial begin
    mif.mem_ack   = 1'b0;
    mif.mem_rdata = 32'h0;
  end

  always @(posedge clk) begin
    #1;
    if (rst || !mif.mem_req) begin
      mif.mem_ack   = 1'($urandom_range(0, 1));
      mif.mem_rdata = $urandom;
      ridx          = 0;
    end else begin
      if (ridx == cur_delay) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = cur_rdata;
      end else begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = $urandom;
      end
      ridx++;
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      req_cnt   = 0;
      stall_cnt = 0;
      req_prev  = 1'b0;
    end else begin
      if (mif.mem_req) begin
        if (!req_prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got mem_req=1, expected no request");
          end else begin
            check("mem_addr", mif.mem_addr, exp_q[0].addr);
            check("mem_be", {28'h0, mif.mem_be}, {28'h0, exp_q[0].be});
            check("mem_we", {31'h0, mif.mem_we}, {31'h0, exp_q[0].we});
            if (exp_q[0].we) check("mem_wdata", mif.mem_wdata, exp_q[0].wdata);
          end
        end
        req_cnt++;
      end
      req_prev = mif.mem_req;
      if (lsu_stall) stall_cnt++;
      if (lsu_done || lsu_err) begin
        ev_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got done=%0b err=%0b, expected none", lsu_done, lsu_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", {31'h0, lsu_err}, {31'h0, e.err});
          check("resp_done", {31'h0, lsu_done}, {31'h0, !e.err});
          check("resp_rdata", lsu_rdata, e.rdata);
          check("req_cycles", req_cnt, e.req_cyc);
          check("stall_cycles", stall_cnt, e.stall_cyc);
          check("stall_in_resp", {31'h0, lsu_stall}, 32'h0);
        end
        req_cnt   = 0;
        stall_cnt = 0;
      end
    end
  end

  task automatic issue(input bit ld, input bit sto, input logic [2:0] ltv, input logic [1:0] stv,
                       input logic [31:0] a, input logic [31:0] wd, input int delay,
                       input logic [31:0] rd);
    @(posedge clk);
    #1;
    cur_delay = delay;
    cur_rdata = rd;
    exp_q.push_back(model(ld, sto, ltv, stv, a, wd, delay, rd));
    lsu_load      = ld;
    lsu_store     = sto;
    lsu_loadtype  = ltv;
    lsu_storetype = stv;
    lsu_addr      = a;
    lsu_wdata     = wd;
    @(posedge clk);
    #1;
    lsu_load  = 1'b0;
    lsu_store = 1'b0;
    lsu_addr  = $urandom;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL resp_timeout: got no done/err within 60 cycles, expected a response");
      exp_q.delete();
    end
  endtask

  initial begin
    int ev_before;
    rst           = 1'b1;
    lsu_load      = 1'b0;
    lsu_store     = 1'b0;
    lsu_loadtype  = 3'd0;
    lsu_storetype = 2'd0;
    lsu_addr      = 32'h0;
    lsu_wdata     = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'h0, mif.mem_req}, 32'h0);
    check("rst_mem_we", {31'h0, mif.mem_we}, 32'h0);
    check("rst_mem_addr", mif.mem_addr, 32'h0);
    check("rst_mem_be", {28'h0, mif.mem_be}, 32'h0);
    check("rst_mem_wdata", mif.mem_wdata, 32'h0);
    check("rst_done", {31'h0, lsu_done}, 32'h0);
    check("rst_err", {31'h0, lsu_err}, 32'h0);
    check("rst_rdata", lsu_rdata, 32'h0);
    check("rst_stall", {31'h0, lsu_stall}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(1'b0, 1'b1, 3'd0, 2'b10, 32'h104, 32'hDEAD_BEEF, 0, 32'h0);          // SW
    issue(1'b0, 1'b1, 3'd0, 2'b00, 32'h103, 32'h0000_00A5, 1, 32'h0);          // SB
    issue(1'b1, 1'b0, 3'b000, 2'd0, 32'h102, 32'h0, 4, 32'h12F3_4567);         // LB
    issue(1'b1, 1'b0, 3'b011, 2'd0, 32'h102, 32'h0, 4, 32'h12F3_4567);         // LBU
    issue(1'b1, 1'b0, 3'b100, 2'd0, 32'h102, 32'h0, 2, 32'h8001_0000);         // LHU
    issue(1'b1, 1'b0, 3'b001, 2'd0, 32'h102, 32'h0, 0, 32'h8001_0000);         // LH
    issue(1'b1, 1'b0, 3'b010, 2'd0, 32'h40, 32'h0, TIMEOUT, 32'h0);            // timeout
    issue(1'b1, 1'b0, 3'b010, 2'd0, 32'h44, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D); // last-cycle ack
    issue(1'b1, 1'b0, 3'b010, 2'd0, 32'h102, 32'h0, 0, 32'h1357_9BDF);         // misaligned LW
    issue(1'b0, 1'b1, 3'd0, 2'b01, 32'h201, 32'h0000_BEEF, 1, 32'h0);          // misaligned SH
    issue(1'b1, 1'b1, 3'd0, 2'd0, 32'h300, 32'h1, 0, 32'h0);                   // load+store

    // Reset while REQ is outstanding; the memory's ack afterwards must be ignored.
    @(posedge clk);
    #1;
    cur_delay = 2;
    cur_rdata = 32'h5555_AAAA;
    exp_q.push_back(model(1'b1, 1'b0, 3'b010, 2'd0, 32'h200, 32'h0, 2, 32'h5555_AAAA));
    lsu_load     = 1'b1;
    lsu_loadtype = 3'b010;
    lsu_addr     = 32'h200;
    @(posedge clk);
    #1;
    lsu_load = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("req_before_rst", {31'h0, mif.mem_req}, 32'h1);
    @(negedge clk);
    check("req_after_rst", {31'h0, mif.mem_req}, 32'h0);
    check("stall_after_rst", {31'h0, lsu_stall}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ev_before = ev_cnt;
    repeat (8) @(posedge clk);
    check("late_ack_ignored", ev_cnt, ev_before);

    for (int k = 0; k < 150; k++) begin
      int          r, dly;
      bit          ld, sto;
      logic [2:0]  ltv;
      logic [1:0]  stv;
      r   = int'($urandom_range(0, 19));
      ld  = (r == 0) || (r < 10);
      sto = (r == 0) || (r >= 10);
      ltv = 3'($urandom_range(0, 7));
      stv = 2'($urandom_range(0, 3));
      dly = ($urandom_range(0, 15) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                         : int'($urandom_range(0, 5));
      issue(ld, sto, ltv, stv, $urandom, $urandom, dly, $urandom);
    end

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
